// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: opcodes, FSM state encoding,
// default widths and the opcode legality helper.
// No ports (package).
package shift_sequencer_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;

  localparam logic [2:0] OP_SLA  = 3'b000;
  localparam logic [2:0] OP_SRAI = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_SLA) || (op == OP_SRAI);
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle between issue logic (master) and the
// shift sequencer (slave).
//   start_valid/start_ready : request handshake; opcode, operand, shamt ride with it
//   result_valid/result_ready: result handshake; result, illegal_op ride with it
//   busy                     : sequencer is in SHIFT or DONE
interface shift_sequencer_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) ();
  logic               start_valid;
  logic               start_ready;
  logic [2:0]         opcode;
  logic [WIDTH-1:0]   operand;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   result;
  logic               result_valid;
  logic               result_ready;
  logic               illegal_op;
  logic               busy;

  modport master (
    output start_valid, opcode, operand, shamt, result_ready,
    input  start_ready, result, result_valid, illegal_op, busy
  );

  modport slave (
    input  start_valid, opcode, operand, shamt, result_ready,
    output start_ready, result, result_valid, illegal_op, busy
  );
endinterface

// File: rtl/shift_sequencer_step.sv
// Combinational single-bit arithmetic shift.
//   i_work  : value to shift
//   i_right : 0 = SLA (left, zero in at LSB), 1 = SRAI (right, sign replicated)
//   o_work  : shifted value; the bit shifted out is dropped
module shift_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_work,
  input  logic             i_right,
  output logic [WIDTH-1:0] o_work
);

  assign o_work = i_right ? {i_work[WIDTH-1], i_work[WIDTH-1:1]}
                          : {i_work[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle variable shift: accepts one request, applies one SLA/SRAI
// step per clock for shamt clocks, then holds the result until taken.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : shift_sequencer_if.slave (request + result handshakes)
// Build option: SHIFT_SEQ_EARLY_EXIT_EN ends the run as soon as further
// steps cannot change the work value (same result, shorter latency).
//
// state    | meaning
// ST_IDLE  | ready for a request
// ST_SHIFT | stepping the work register, count holds steps remaining
// ST_DONE  | result presented, waiting for result_ready
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic                clk,
  input  logic                rst,
  shift_sequencer_if.slave    bus
);

  state_t             r_state;
  logic [WIDTH-1:0]   r_work;
  logic [SHAMT_W-1:0] r_count;
  logic [2:0]         r_op;
  logic               r_result_valid;
  logic               r_illegal_op;
  logic               r_busy;
  logic               r_start_ready;

  logic [WIDTH-1:0]   w_step;
  logic               w_legal_in;
  logic               w_exit_now;
  logic               w_exit_accept;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_work  (r_work),
    .i_right (r_op == OP_SRAI),
    .o_work  (w_step)
  );

  assign w_legal_in = op_is_legal(bus.opcode);

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  // Fixed points of the step: nothing left to shift in either direction.
  function automatic logic is_fixed(input logic [WIDTH-1:0] work, input logic [2:0] op);
    return (work == '0) || ((op == OP_SRAI) && (work == '1));
  endfunction

  assign w_exit_now    = is_fixed(r_work, r_op);
  assign w_exit_accept = is_fixed(bus.operand, bus.opcode);
`else
  assign w_exit_now    = 1'b0;
  assign w_exit_accept = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_work         <= '0;
      r_count        <= '0;
      r_op           <= '0;
      r_result_valid <= 1'b0;
      r_illegal_op   <= 1'b0;
      r_busy         <= 1'b0;
      r_start_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start_valid && r_start_ready) begin
            r_work        <= bus.operand;
            r_op          <= bus.opcode;
            r_count       <= bus.shamt;
            r_illegal_op  <= ~w_legal_in;
            r_busy        <= 1'b1;
            r_start_ready <= 1'b0;
            if (!w_legal_in || (bus.shamt == '0) || w_exit_accept) begin
              r_state        <= ST_DONE;
              r_result_valid <= 1'b1;
            end else begin
              r_state <= ST_SHIFT;
            end
          end
        end

        ST_SHIFT: begin
          r_work  <= w_step;
          r_count <= r_count - 1'b1;
          // count==1 means this edge applies the final step
          if ((r_count == SHAMT_W'(1)) || w_exit_now) begin
            r_state        <= ST_DONE;
            r_result_valid <= 1'b1;
          end
        end

        ST_DONE: begin
          if (bus.result_ready) begin
            r_state        <= ST_IDLE;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_start_ready  <= 1'b1;
          end
        end

        default: begin
          r_state        <= ST_IDLE;
          r_result_valid <= 1'b0;
          r_busy         <= 1'b0;
          r_start_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.result       = r_work;
  assign bus.result_valid = r_result_valid;
  assign bus.illegal_op   = r_illegal_op;
  assign bus.busy         = r_busy;
  assign bus.start_ready  = r_start_ready;

endmodule
